// File: rtl/uart_msg_rx_pkg.sv
// Shared constants for the UART message receiver: type codes, terminators, matcher patterns.
package uart_msg_rx_pkg;

    localparam int unsigned DEFAULT_CLKS_PER_BIT = 434;
    localparam int unsigned MSG_LEN_W            = 5;

    localparam logic [1:0] MSG_UNKNOWN = 2'd0;
    localparam logic [1:0] MSG_IDENT   = 2'd1;
    localparam logic [1:0] MSG_PICK    = 2'd2;
    localparam logic [1:0] MSG_DUMP    = 2'd3;

    localparam logic [7:0] TERM_HASH = 8'h23;
    localparam logic [7:0] TERM_NUL  = 8'h00;

    localparam logic [31:0] PAT_DUMP = "DUMP";
    localparam logic [31:0] PAT_PICK = "PICK";
    localparam logic [23:0] PAT_GBI  = "GBI";

    // One step of a 4-character substring matcher; returns {hit, next_progress}.
    // The patterns used have no repeated letters, so a miss only needs to
    // re-check the first character.
    function automatic logic [2:0] match_step(input logic [1:0]  st,
                                              input logic [7:0]  b,
                                              input logic [31:0] pat);
        logic [7:0] want;
        case (st)
            2'd0:    want = pat[31:24];
            2'd1:    want = pat[23:16];
            2'd2:    want = pat[15:8];
            default: want = pat[7:0];
        endcase
        if (b == want) begin
            if (st == 2'd3) match_step = {1'b1, 2'd0};
            else            match_step = {1'b0, st + 2'd1};
        end else if (b == pat[31:24]) begin
            match_step = {1'b0, 2'd1};
        end else begin
            match_step = {1'b0, 2'd0};
        end
    endfunction

endpackage

// File: rtl/uart_rx_byte.sv
// 8N1 UART byte receiver with input synchronizer, glitch rejection and frame error reporting.
module uart_rx_byte
    import uart_msg_rx_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    output logic [7:0] rx_byte,
    output logic       rx_byte_valid,
    output logic       frame_err
);

    localparam int unsigned TMR_W = $clog2(CLKS_PER_BIT);
    localparam logic [TMR_W-1:0] T_HALF = TMR_W'(CLKS_PER_BIT / 2);
    localparam logic [TMR_W-1:0] T_LAST = TMR_W'(CLKS_PER_BIT - 1);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_START   = 3'd1;
    localparam logic [2:0] S_DATA    = 3'd2;
    localparam logic [2:0] S_STOP    = 3'd3;
    localparam logic [2:0] S_RECOVER = 3'd4;

    logic             r_sync1, r_sync2, r_rx_d;
    logic [2:0]       r_state, w_state_nxt;
    logic [TMR_W-1:0] r_timer, w_timer_nxt;
    logic [2:0]       r_bit_cnt, w_bit_cnt_nxt;
    logic [7:0]       r_shift, w_shift_nxt;
    logic [7:0]       r_byte, w_byte_nxt;
    logic             r_valid, w_valid_nxt;
    logic             r_ferr, w_ferr_nxt;
    logic             w_rx;

    assign w_rx          = r_sync2;
    assign rx_byte       = r_byte;
    assign rx_byte_valid = r_valid;
    assign frame_err     = r_ferr;

    // State, timer, shift register and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync1   <= 1'b1;
            r_sync2   <= 1'b1;
            r_rx_d    <= 1'b1;
            r_state   <= S_IDLE;
            r_timer   <= '0;
            r_bit_cnt <= '0;
            r_shift   <= '0;
            r_byte    <= '0;
            r_valid   <= 1'b0;
            r_ferr    <= 1'b0;
        end else begin
            r_sync1   <= rx;
            r_sync2   <= r_sync1;
            r_rx_d    <= r_sync2;
            r_state   <= w_state_nxt;
            r_timer   <= w_timer_nxt;
            r_bit_cnt <= w_bit_cnt_nxt;
            r_shift   <= w_shift_nxt;
            r_byte    <= w_byte_nxt;
            r_valid   <= w_valid_nxt;
            r_ferr    <= w_ferr_nxt;
        end
    end

    // Next-state and datapath decisions on the synchronized line
    always_comb begin
        w_state_nxt   = r_state;
        w_timer_nxt   = r_timer + TMR_W'(1);
        w_bit_cnt_nxt = r_bit_cnt;
        w_shift_nxt   = r_shift;
        w_byte_nxt    = r_byte;
        w_valid_nxt   = 1'b0;
        w_ferr_nxt    = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_timer_nxt = '0;
                if (r_rx_d && !w_rx) w_state_nxt = S_START;
            end
            S_START: begin
                if (r_timer == T_HALF) begin
                    w_timer_nxt   = '0;
                    w_bit_cnt_nxt = '0;
                    w_state_nxt   = w_rx ? S_IDLE : S_DATA;
                end
            end
            S_DATA: begin
                if (r_timer == T_LAST) begin
                    w_timer_nxt   = '0;
                    w_shift_nxt   = {w_rx, r_shift[7:1]};
                    w_bit_cnt_nxt = r_bit_cnt + 3'd1;
                    if (r_bit_cnt == 3'd7) w_state_nxt = S_STOP;
                end
            end
            S_STOP: begin
                if (r_timer == T_LAST) begin
                    w_timer_nxt = '0;
                    if (w_rx) begin
                        w_byte_nxt  = r_shift;
                        w_valid_nxt = 1'b1;
                        w_state_nxt = S_IDLE;
                    end else begin
                        w_ferr_nxt  = 1'b1;
                        w_state_nxt = S_RECOVER;
                    end
                end
            end
            S_RECOVER: begin
                w_timer_nxt = '0;
                if (w_rx) w_state_nxt = S_IDLE;
            end
            default: begin
                w_timer_nxt = '0;
                w_state_nxt = S_IDLE;
            end
        endcase
    end

endmodule

// File: rtl/uart_msg_rx.sv
// UART message receiver: assembles terminated messages and classifies them on the fly.
module uart_msg_rx
    import uart_msg_rx_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
    parameter int unsigned MAX_LEN      = 24
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rx,
    output logic [7:0]           rx_byte,
    output logic                 rx_byte_valid,
    output logic                 frame_err,
    output logic                 msg_valid,
    output logic [1:0]           msg_type,
    output logic [MSG_LEN_W-1:0] msg_len,
    output logic                 msg_overflow
);

    localparam logic [MSG_LEN_W-1:0] LEN_MAX = MSG_LEN_W'(MAX_LEN);

    logic [MSG_LEN_W-1:0] r_len;
    logic                 r_ovf;
    logic [1:0]           r_dump_st, r_pick_st, r_gbi_cnt;
    logic                 r_dump_hit, r_pick_hit;
    logic                 r_msg_valid, r_msg_ovf;
    logic [1:0]           r_msg_type;
    logic [MSG_LEN_W-1:0] r_msg_len;

    logic       w_is_hash, w_is_nul, w_term, w_data, w_append, w_drop, w_gbi_adv;
    logic [2:0] w_dump_step, w_pick_step;
    logic [7:0] w_gbi_want;
    logic [1:0] w_type;

    uart_rx_byte #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_rx_byte (
        .clk           (clk),
        .rst           (rst),
        .rx            (rx),
        .rx_byte       (rx_byte),
        .rx_byte_valid (rx_byte_valid),
        .frame_err     (frame_err)
    );

    assign msg_valid    = r_msg_valid;
    assign msg_type     = r_msg_type;
    assign msg_len      = r_msg_len;
    assign msg_overflow = r_msg_ovf;

    assign w_is_hash   = (rx_byte == TERM_HASH);
    assign w_is_nul    = (rx_byte == TERM_NUL);
    assign w_term      = rx_byte_valid && (w_is_hash || (w_is_nul && (r_len != '0)));
    assign w_data      = rx_byte_valid && !w_is_hash && !w_is_nul;
    assign w_append    = w_data && (r_len < LEN_MAX);
    assign w_drop      = w_data && (r_len >= LEN_MAX);
    assign w_dump_step = match_step(r_dump_st, rx_byte, PAT_DUMP);
    assign w_pick_step = match_step(r_pick_st, rx_byte, PAT_PICK);

    // Expected character for the "GBI" prefix at the current position
    always_comb begin
        w_gbi_want = 8'h00;
        case (r_len)
            MSG_LEN_W'(0): w_gbi_want = PAT_GBI[23:16];
            MSG_LEN_W'(1): w_gbi_want = PAT_GBI[15:8];
            MSG_LEN_W'(2): w_gbi_want = PAT_GBI[7:0];
            default:       w_gbi_want = 8'h00;
        endcase
    end

    assign w_gbi_adv = (r_len < MSG_LEN_W'(3)) && (r_gbi_cnt == r_len[1:0])
                       && (rx_byte == w_gbi_want);

    // Message type priority: overflow, DUMP, PICK, GBI prefix
    always_comb begin
        w_type = MSG_UNKNOWN;
        if (!r_ovf) begin
            if (r_dump_hit)              w_type = MSG_DUMP;
            else if (r_pick_hit)         w_type = MSG_PICK;
            else if (r_gbi_cnt == 2'd3)  w_type = MSG_IDENT;
        end
    end

    // Message assembly, incremental matchers and held message outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            r_len       <= '0;
            r_ovf       <= 1'b0;
            r_dump_st   <= '0;
            r_pick_st   <= '0;
            r_gbi_cnt   <= '0;
            r_dump_hit  <= 1'b0;
            r_pick_hit  <= 1'b0;
            r_msg_valid <= 1'b0;
            r_msg_type  <= MSG_UNKNOWN;
            r_msg_len   <= '0;
            r_msg_ovf   <= 1'b0;
        end else begin
            r_msg_valid <= 1'b0;
            if (frame_err || w_term) begin
                if (w_term) begin
                    r_msg_valid <= 1'b1;
                    r_msg_type  <= w_type;
                    r_msg_len   <= r_len;
                    r_msg_ovf   <= r_ovf;
                end
                r_len      <= '0;
                r_ovf      <= 1'b0;
                r_dump_st  <= '0;
                r_pick_st  <= '0;
                r_gbi_cnt  <= '0;
                r_dump_hit <= 1'b0;
                r_pick_hit <= 1'b0;
            end else if (w_append) begin
                r_len      <= r_len + MSG_LEN_W'(1);
                r_dump_st  <= w_dump_step[1:0];
                r_pick_st  <= w_pick_step[1:0];
                r_dump_hit <= r_dump_hit | w_dump_step[2];
                r_pick_hit <= r_pick_hit | w_pick_step[2];
                if (w_gbi_adv) r_gbi_cnt <= r_gbi_cnt + 2'd1;
            end else if (w_drop) begin
                r_ovf <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_uart_msg_rx.sv
// Directed scoreboard bench for uart_msg_rx: a string-scanning message model feeds expectation queues.
module tb_uart_msg_rx;
    import uart_msg_rx_pkg::*;

    localparam int unsigned CPB     = 32;
    localparam int unsigned MAX_LEN = 24;

    typedef struct packed {
        logic [1:0] t;
        logic [4:0] l;
        logic       o;
    } msg_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       rx;
    logic [7:0] rx_byte;
    logic       rx_byte_valid, frame_err, msg_valid, msg_overflow;
    logic [1:0] msg_type;
    logic [4:0] msg_len;

    logic [7:0] byte_q[$];
    msg_t       msg_q[$];
    logic [7:0] m_buf[$];
    bit         m_ovf;
    logic       prev_mv = 1'b0;

    int total = 0, bad = 0;
    int byte_seen = 0, msg_seen = 0, fe_seen = 0, fe_exp = 0;
    int b0, m0, f0;

    always #5 clk = ~clk;

    uart_msg_rx #(
        .CLKS_PER_BIT (CPB),
        .MAX_LEN      (MAX_LEN)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .rx            (rx),
        .rx_byte       (rx_byte),
        .rx_byte_valid (rx_byte_valid),
        .frame_err     (frame_err),
        .msg_valid     (msg_valid),
        .msg_type      (msg_type),
        .msg_len       (msg_len),
        .msg_overflow  (msg_overflow)
    );

    task automatic chk(input string tag, input int obs, input int exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic bit has_at(input int i, input logic [31:0] pat);
        for (int k = 0; k < 4; k++)
            if (m_buf[i+k] != pat[31-8*k -: 8]) return 1'b0;
        return 1'b1;
    endfunction

    function automatic logic [1:0] classify();
        if (m_ovf) return MSG_UNKNOWN;
        for (int i = 0; i + 4 <= m_buf.size(); i++)
            if (has_at(i, "DUMP")) return MSG_DUMP;
        for (int i = 0; i + 4 <= m_buf.size(); i++)
            if (has_at(i, "PICK")) return MSG_PICK;
        if (m_buf.size() >= 3 && m_buf[0] == "G" && m_buf[1] == "B" && m_buf[2] == "I")
            return MSG_IDENT;
        return MSG_UNKNOWN;
    endfunction

    task automatic model_clear();
        m_buf.delete();
        m_ovf = 1'b0;
    endtask

    task automatic model_byte(input logic [7:0] b);
        msg_t m;
        byte_q.push_back(b);
        if (b == 8'h23 || (b == 8'h00 && m_buf.size() > 0)) begin
            m.t = classify();
            m.l = 5'(m_buf.size());
            m.o = m_ovf;
            msg_q.push_back(m);
            model_clear();
        end else if (b != 8'h00) begin
            if (m_buf.size() < MAX_LEN) m_buf.push_back(b);
            else                        m_ovf = 1'b1;
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input bit stop_ok);
        rx = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            repeat (CPB) @(negedge clk);
        end
        rx = stop_ok;
        if (stop_ok) model_byte(b);
        else begin
            fe_exp++;
            model_clear();
        end
        repeat (CPB) @(negedge clk);
        rx = 1'b1;
    endtask

    task automatic send_str(input string s);
        for (int i = 0; i < s.len(); i++) send_byte(s[i], 1'b1);
    endtask

    task automatic drain(input string tag);
        int n = 0;
        while ((byte_q.size() + msg_q.size()) > 0 && n < 20 * CPB) begin
            @(negedge clk);
            n++;
        end
        repeat (4) @(negedge clk);
        chk(tag, byte_q.size() + msg_q.size(), 0);
    endtask

    task automatic chk_msg(input string tag, input logic [1:0] t, input int l, input logic o);
        chk({tag, "_type"}, int'(msg_type), int'(t));
        chk({tag, "_len"}, int'(msg_len), l);
        chk({tag, "_ovf"}, int'(msg_overflow), int'(o));
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_rx_byte"}, int'(rx_byte), 0);
        chk({tag, "_rx_byte_valid"}, int'(rx_byte_valid), 0);
        chk({tag, "_frame_err"}, int'(frame_err), 0);
        chk({tag, "_msg_valid"}, int'(msg_valid), 0);
        chk_msg(tag, 2'd0, 0, 1'b0);
    endtask

    // Output monitor: pops expectations whenever the DUT pulses
    always @(negedge clk) begin
        if (rx_byte_valid) begin
            byte_seen++;
            chk("byte_expected", int'(byte_q.size() > 0), 1);
            if (byte_q.size() > 0) chk("rx_byte", int'(rx_byte), int'(byte_q.pop_front()));
        end
        if (msg_valid) begin
            msg_t m;
            msg_seen++;
            chk("msg_single_pulse", int'(prev_mv), 0);
            chk("msg_expected", int'(msg_q.size() > 0), 1);
            if (msg_q.size() > 0) begin
                m = msg_q.pop_front();
                chk("sb_msg_type", int'(msg_type), int'(m.t));
                chk("sb_msg_len", int'(msg_len), int'(m.l));
                chk("sb_msg_ovf", int'(msg_overflow), int'(m.o));
            end
        end
        if (frame_err) fe_seen++;
        prev_mv = msg_valid;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        rx  = 1'b1;
        model_clear();
        repeat (4) @(negedge clk);
        chk_zero("reset");
        rst = 1'b0;
        repeat (2 * CPB) @(negedge clk);

        b0 = byte_seen; m0 = msg_seen;
        send_str("GBI2-W-#");
        drain("ident_drain");
        chk("ident_bytes", byte_seen - b0, 8);
        chk("ident_msgs", msg_seen - m0, 1);
        chk_msg("ident", MSG_IDENT, 7, 1'b0);

        b0 = byte_seen; m0 = msg_seen;
        send_str("GB2-W-PICK-#");
        send_byte(8'h00, 1'b1);
        drain("pick_drain");
        chk("pick_bytes", byte_seen - b0, 13);
        chk("pick_msgs", msg_seen - m0, 1);
        chk_msg("pick", MSG_PICK, 11, 1'b0);

        m0 = msg_seen;
        send_str("GB2-W-GDZC-DUMP");
        send_byte(8'h00, 1'b1);
        drain("dump_drain");
        chk("dump_msgs", msg_seen - m0, 1);
        chk_msg("dump", MSG_DUMP, 15, 1'b0);

        b0 = byte_seen; f0 = fe_seen;
        rx = 1'b0;
        repeat (CPB / 2 - 6) @(negedge clk);
        rx = 1'b1;
        repeat (3 * CPB) @(negedge clk);
        chk("glitch_bytes", byte_seen - b0, 0);
        chk("glitch_ferr", fe_seen - f0, 0);
        send_byte(8'h5A, 1'b1);
        send_byte(8'h23, 1'b1);
        drain("glitch_drain");
        chk("glitch_next_bytes", byte_seen - b0, 2);
        chk_msg("glitch_next", MSG_UNKNOWN, 1, 1'b0);

        m0 = msg_seen; f0 = fe_seen;
        send_str("GB2");
        send_byte(8'h41, 1'b0);
        rx = 1'b1;
        repeat (2 * CPB) @(negedge clk);
        chk("ferr_once", fe_seen - f0, 1);
        chk("ferr_no_msg", msg_seen - m0, 0);
        send_str("GBI#");
        drain("ferr_drain");
        chk("ferr_msgs", msg_seen - m0, 1);
        chk_msg("ferr_after", MSG_IDENT, 3, 1'b0);

        m0 = msg_seen;
        repeat (30) send_byte(8'h41, 1'b1);
        send_byte(8'h23, 1'b1);
        drain("ovf_drain");
        chk("ovf_msgs", msg_seen - m0, 1);
        chk_msg("ovf", MSG_UNKNOWN, 24, 1'b1);

        b0 = byte_seen; m0 = msg_seen;
        rx = 1'b0;
        repeat (CPB * 3 / 2) @(negedge clk);
        rst = 1'b1;
        rx  = 1'b1;
        model_clear();
        repeat (3) @(negedge clk);
        chk_zero("midrst");
        rst = 1'b0;
        repeat (3 * CPB) @(negedge clk);
        chk("midrst_bytes", byte_seen - b0, 0);
        chk("midrst_msgs", msg_seen - m0, 0);
        send_str("GBI#");
        drain("midrst_drain");
        chk("midrst_after_msgs", msg_seen - m0, 1);
        chk_msg("midrst_after", MSG_IDENT, 3, 1'b0);

        chk("ferr_total", fe_seen, fe_exp);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/uart_msg_rx.md
UART_MSG_RX -- requirements
Module: uart_msg_rx

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 434: clocks per UART bit (50 MHz, 115200 baud).
REQ-002 SHALL have parameter MAX_LEN, default 24: message buffer depth in bytes.
REQ-003 SHALL have port clk  input  1  single system clock; all logic on posedge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port rx  input  1  asynchronous serial line, idle high, 8N1, LSB first.
REQ-006 SHALL have port rx_byte  output  8  last received data byte.
REQ-007 SHALL have port rx_byte_valid  output  1  one-cycle pulse when rx_byte is updated.
REQ-008 SHALL have port frame_err  output  1  one-cycle pulse when the stop bit samples low.
REQ-009 SHALL have port msg_valid  output  1  one-cycle pulse when a complete message is available.
REQ-010 SHALL have port msg_type  output  2  0 UNKNOWN, 1 IDENT, 2 PICK, 3 DUMP; held until the next msg_valid.
REQ-011 SHALL have port msg_len  output  5  byte count of the message, terminator excluded; held until the next msg_valid.
REQ-012 SHALL have port msg_overflow  output  1  set with msg_valid when bytes were dropped; held until the next msg_valid.

Function
REQ-013 rx SHALL pass through a 2-flop synchronizer whose flops reset to 1; all decisions use the synchronized value.
REQ-014 The receiver FSM SHALL have states IDLE, START, DATA, STOP and RECOVER.
REQ-015 IDLE: a synchronized high-to-low transition SHALL move the FSM to START and clear the bit timer.
REQ-016 START: at timer = CLKS_PER_BIT/2 the line is sampled; low -> DATA with the timer cleared; high -> IDLE (glitch, no output).
REQ-017 DATA: a bit SHALL be sampled each time the timer reaches CLKS_PER_BIT-1 and shifted in LSB first; after 8 bits the FSM moves to STOP.
REQ-018 STOP: the line is sampled one bit time after the last data bit; high -> rx_byte updated and rx_byte_valid pulsed on the next cycle, then IDLE.
REQ-019 STOP with low sample -> frame_err pulsed, byte discarded, FSM to RECOVER.
REQ-020 RECOVER SHALL wait for the synchronized line to be high, then return to IDLE.
REQ-021 The message layer SHALL append each valid byte other than 0x23 ('#') and 0x00 to a buffer while the length count is below MAX_LEN.
REQ-022 Bytes arriving when the length count equals MAX_LEN SHALL be dropped, and an internal overflow flag SHALL be set.
REQ-023 On 0x23, or on 0x00 with length > 0, msg_valid SHALL pulse one cycle after rx_byte_valid, with msg_type, msg_len and msg_overflow loaded in the same cycle.
REQ-024 After msg_valid, the length count and all matchers SHALL clear.
REQ-025 0x00 with length = 0 SHALL be ignored, so a "#" followed by NUL yields exactly one message; 0x23 with length = 0 SHALL report msg_len 0, type UNKNOWN.
REQ-026 Classification SHALL use matchers that run incrementally on each appended byte, with no buffer rescan: DUMP if "DUMP" occurs anywhere; else PICK if "PICK" occurs; else IDENT if bytes 0..2 are "GBI"; else UNKNOWN.
REQ-027 An overflowed message SHALL report msg_len = MAX_LEN, msg_overflow = 1 and type UNKNOWN.
REQ-028 A frame_err SHALL discard the partial message: length, matchers and overflow flag clear, and no msg_valid is produced.
REQ-029 rx_byte_valid and msg_valid MAY be high in the same cycle only when rx_byte_valid belongs to a new byte; simultaneous events SHALL both be processed.

Reset
REQ-030 rst SHALL force: FSM IDLE, timer 0, synchronizer 1, rx_byte 0x00, all pulse outputs 0, msg_type 0, msg_len 0, msg_overflow 0, buffer count 0.
REQ-031 rst asserted mid-byte SHALL abandon the byte with no output; reception restarts on the next falling edge after release.

Structure
REQ-032 A shared package SHALL hold the msg_type encoding constants, the terminator codes 0x23 and 0x00, and the default CLKS_PER_BIT.
REQ-033 The bit-level receiver SHALL be a sub-module uart_rx_byte (ports clk, rst, rx, rx_byte, rx_byte_valid, frame_err); message assembly and classification stay in uart_msg_rx.

Verification
REQ-034 "GBI2-W-#" at 434 clk/bit -> 8 rx_byte_valid pulses, one msg_valid, type 1, len 7, overflow 0.
REQ-035 "GB2-W-PICK-#" followed by 0x00 -> one msg_valid, type 2, len 11; the trailing NUL produces no message.
REQ-036 "GB2-W-GDZC-DUMP" followed by 0x00 -> one msg_valid, type 3, len 15.
REQ-037 rx low for 100 cycles, then high -> no rx_byte_valid and no frame_err; the next valid byte is received correctly.
REQ-038 "GB2" then a byte 0x41 with stop bit 0, then "GBI#" -> frame_err once; msg_valid with type 1, len 3.
REQ-039 30 x 0x41 then '#' -> msg_valid with len 24, overflow 1, type 0; rst pulsed mid-byte afterwards -> all outputs 0 and a subsequent "GBI#" decodes as type 1, len 3.
